uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receive front-end of the memory-mapped Peripheral block.
- Oversamples the UART_RX pin, deframes 8N1 characters and buffers them in a small show-ahead FIFO.
- The Peripheral reads bytes through a pop handshake. The FIFO raises a level interrupt request, which the Peripheral merges into irqout toward the CPU.

Parameters:
- CLK_HZ, 50_000_000, sysclk frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- OVS_DIV, CLK_HZ/(BAUD*16) (integer division), clocks per 16x oversample tick; derived, must be at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- UART_RX  in  1  raw serial line; idle high; asynchronous to clk.
- rd_en  in  1  pop the head byte; sampled on posedge.
- clr_err  in  1  clear ferr and ovr.
- rx_data  out  8  head byte of the FIFO (show-ahead); 0 when empty.
- rx_valid  out  1  FIFO non-empty.
- count  out  $clog2(DEPTH)+1  current occupancy.
- ferr  out  1  sticky framing-error flag.
- ovr  out  1  sticky overrun flag.
- irq  out  1  equals rx_valid.

Behaviour:

Reset:
- Reset is asynchronous and active-high. It takes effect immediately, independent of clk.
- While reset is asserted: all outputs are 0, both synchronizer flops are 1, the FSM is in IDLE, the tick counter is 0, and the FIFO pointers are 0.
- Reset asserted mid-frame discards the partial byte. Stored bytes are lost.

Input synchronizer and tick:
- UART_RX passes through a 2-flop synchronizer (rx_s); add 2 cycles latency.
- A tick counter counts 0..OVS_DIV-1 and pulses tick for one clk when it wraps.
- The counter runs freely, except that it restarts at 0 on the IDLE to START transition.

FSM (advances only on tick, except IDLE):
- IDLE: on any clk where rx_s=0, go to START and set sample count s=0.
- START: on tick s=7, if rx_s=0 go to DATA with bit index b=0 and s=0. If rx_s=1, treat as a glitch and go back to IDLE with no flags set.
- DATA: sample at s=15 (the mid-bit point). Shift in LSB first. After b=7, go to STOP.
- STOP, sample at s=15:
  - rx_s=1: push the byte and go to IDLE.
  - rx_s=0: drop the byte, set ferr, and go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. This means a held-low line produces exactly one ferr and no bytes.

FIFO:
- The push lands in the clk after the STOP sample tick. rx_valid rises in that same following cycle.
- rd_en with count>0 pops: the next head appears the following cycle. rd_en with count=0 is ignored and has no side effect.
- Push while count=DEPTH and no pop: drop the new byte, set ovr, and leave contents unchanged.
- Push and pop in the same cycle:
  - when full: both take effect, count is unchanged and ovr is not set;
  - when empty: the push proceeds and the pop is ignored, so count goes to 1.
- Pointers wrap modulo DEPTH. count saturates at 0..DEPTH.

Flags:
- ferr and ovr stay set until clr_err. clr_err has priority over a set event in the same cycle.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, STOP, BREAK), OVS=16, MID=7, LAST=15.
- One sub-module, sync_fifo: parameterised by WIDTH and DEPTH; show-ahead read; full/empty/count outputs. It is reused later by the TX path.

Test Plan (CLK_HZ=1_600_000, BAUD=10_000, so OVS_DIV=10 and 160 clk per bit):
- Send 0xA5 as 8N1 with reset released. rx_valid rises between 1,523 and 1,535 clk after the start edge; rx_data=0xA5; irq=1. Pulse rd_en: rx_valid=0 and count=0 the next cycle.
- Drive a 40-clk low glitch on idle UART_RX: FSM returns to IDLE, count=0, ferr=0.
- Send 0x3C with the stop bit held low for 2 bit times, then high: no push, ferr=1, one flag only. clr_err: ferr=0. Then send 0x11: received correctly.
- Send 5 bytes 0x01..0x05 with no pops: count=4, ovr=1, and pops yield 0x01..0x04 in order.
- With FIFO full, assert rd_en in the exact push cycle of a 5th byte 0x55: ovr=0, count=4, and the tail after three more pops is 0x55.
- Assert reset mid-DATA after 3 bits: all outputs 0 immediately. Deassert and send 0x7E: received 0x7E with no ferr.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive and transmit paths.
// This file holds the deframer state encoding and the oversampling constants.
package uart_pkg;

  // Deframer states. BREAK absorbs a line that is held low past the stop bit.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int OVS  = 16;  // oversample ticks per bit
  localparam int MID  = 7;   // start-bit confirmation sample (half a bit in)
  localparam int LAST = 15;  // mid-bit sample for data and stop bits

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is visible on rdata whenever the
// FIFO is non-empty, and rdata reads as 0 when it is empty.
// A push into a full FIFO succeeds only if a pop takes place in the same cycle.
// A pop from an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;
  assign rdata   = empty ? '0 : mem[rd_ptr_reg];

  // Storage array; contents need no reset because the empty state masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth, and the occupancy follows push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver. The serial line is oversampled 16x, each character is
// deframed, and the good bytes are buffered in a show-ahead FIFO.
// A framing error or an overrun sets a sticky flag, and irq follows FIFO non-empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     UART_RX,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ferr,
  output logic                     ovr,
  output logic                     irq
);

  localparam int OVS_DIV = CLK_HZ / (BAUD * OVS);
  localparam int CNT_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  logic             rx_meta_reg;
  logic             rx_s;
  logic [CNT_W-1:0] tick_cnt_reg;
  logic             tick;
  rx_state_t        state_reg, state_next;
  logic [3:0]       s_reg, s_next;
  logic [2:0]       b_reg, b_next;
  logic [7:0]       shift_reg, shift_next;
  logic             push;
  logic             ferr_set;
  logic             restart;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ferr_reg;
  logic             ovr_reg;

  // Two-flop synchronizer. It resets to the idle-high line level so that reset is not seen as a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= UART_RX;
      rx_s        <= rx_meta_reg;
    end
  end

  assign tick = (tick_cnt_reg == CNT_W'(OVS_DIV - 1));

  // Free-running oversample divider. It is realigned to the falling start edge so that the samples land mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        tick_cnt_reg <= '0;
    else if (restart) tick_cnt_reg <= '0;
    else if (tick)    tick_cnt_reg <= '0;
    else              tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // Deframer state, sample counter, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      b_reg     <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      b_reg     <= b_next;
      shift_reg <= shift_next;
    end
  end

  // Deframer next-state logic, with the push and framing-error strobes.
  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    b_next     = b_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    ferr_set   = 1'b0;
    restart    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
          restart    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (s_reg == 4'(MID)) begin
            s_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              b_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_reg == 4'(LAST)) begin
            s_next     = '0;
            shift_next = {rx_s, shift_reg[7:1]};
            if (b_reg == 3'd7) state_next = STOP;
            else               b_next = b_reg + 3'd1;
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_reg == 4'(LAST)) begin
            s_next = '0;
            if (rx_s) begin
              push       = 1'b1;
              state_next = IDLE;
            end else begin
              ferr_set   = 1'b1;
              state_next = BREAK;
            end
          end else begin
            s_next = s_reg + 4'd1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (shift_reg),
    .pop   (rd_en),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // Sticky error flags. A clear in the same cycle as a set event takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ferr_reg <= 1'b0;
      ovr_reg  <= 1'b0;
    end else if (clr_err) begin
      ferr_reg <= 1'b0;
      ovr_reg  <= 1'b0;
    end else begin
      if (ferr_set)                        ferr_reg <= 1'b1;
      if (push && fifo_full && !rd_en)     ovr_reg  <= 1'b1;
    end
  end

  assign rx_valid = !fifo_empty;
  assign irq      = !fifo_empty;
  assign ferr     = ferr_reg;
  assign ovr      = ovr_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo. A byte queue serves as the
// reference model of the receive buffer, and the frames are generated from the 8N1 line rules.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int DEPTH  = 4;
  localparam int BIT_CLK = 160;
  localparam int PUSH_CYCLE = 1522;  // 2 sync + 152 ticks of 10 clk from the start edge

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] count;
  logic       ferr;
  logic       ovr;
  logic       irq;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       model_ovr;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .count    (count),
    .ferr     (ferr),
    .ovr      (ovr),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame, one line value per clock at the negedge.
  // stop_low holds the stop bit low for that many bit times. rd_en is pulsed at
  // cycle pop_at, the frame is abandoned at abort_at, and rise is set to the first cycle with rx_valid high.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input int pop_at,
                            input int abort_at, output int rise);
    int total;
    int bidx;
    logic v;
    total = (10 + stop_low) * BIT_CLK + 40;
    rise = -1;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == abort_at) return;
      if (rise < 0 && rx_valid === 1'b1) rise = i;
      bidx = i / BIT_CLK;
      if (bidx == 0)                 v = 1'b0;
      else if (bidx <= 8)            v = d[bidx-1];
      else if (bidx < 9 + stop_low)  v = 1'b0;
      else                           v = 1'b1;
      UART_RX = v;
      rd_en = (i == pop_at);
    end
    rd_en = 1'b0;
    $display("[TB] frame %02h sent (stop_low=%0d) count=%0d head=%02h", d, stop_low, count, rx_data);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, rx_data, exp);
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    $display("[TB] pop expected %02h", exp);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  // Model push of one good frame.
  task automatic model_push(input logic [7:0] d);
    if (q.size() < DEPTH) q.push_back(d);
    else model_ovr = 1'b1;
  endtask

  initial begin
    int rise;
    logic [7:0] d;
    model_ovr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_count", count, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", ovr, 0);
    check("rst_irq", irq, 0);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    // Test 1: single byte 0xA5 and its latency
    send_frame(8'hA5, 0, -1, -1, rise);
    $display("[TB] A5 rx_valid rise at cycle %0d", rise);
    check("t1_latency", rise, PUSH_CYCLE + 1);
    check("t1_latency_window", (rise >= 1523 && rise <= 1535), 1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_irq", irq, 1);
    check("t1_count", count, 1);
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    check("t1_pop_valid", rx_valid, 0);
    check("t1_pop_count", count, 0);
    // pop on empty has no effect
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
    check("t1_empty_pop_count", count, 0);
    check("t1_empty_pop_data", rx_data, 0);

    // Test 2: 40-clk glitch
    @(negedge clk); UART_RX = 1'b0;
    repeat (40) @(negedge clk);
    UART_RX = 1'b1;
    repeat (300) @(negedge clk);
    $display("[TB] glitch done count=%0d ferr=%0d", count, ferr);
    check("t2_count", count, 0);
    check("t2_ferr", ferr, 0);
    check("t2_valid", rx_valid, 0);

    // Test 3: framing error with stop held low for two bit times
    send_frame(8'h3C, 2, -1, -1, rise);
    check("t3_count", count, 0);
    check("t3_ferr", ferr, 1);
    check("t3_ovr", ovr, 0);
    pulse_clr();
    check("t3_clr_ferr", ferr, 0);
    send_frame(8'h11, 0, -1, -1, rise);
    check("t3_recover_count", count, 1);
    check("t3_recover_ferr", ferr, 0);
    pop_check("t3_recover_data", 8'h11);

    // Test 4: overrun
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k);
      send_frame(d, 0, -1, -1, rise);
      model_push(d);
    end
    check("t4_count", count, DEPTH);
    check("t4_ovr", ovr, model_ovr);
    check("t4_ovr_set", ovr, 1);
    while (q.size() > 0) pop_check("t4_pop_order", q.pop_front());
    check("t4_drained", count, 0);
    pulse_clr();
    model_ovr = 1'b0;
    check("t4_clr_ovr", ovr, 0);

    // Test 5: push and pop in the same cycle while full
    for (int k = 0; k < DEPTH; k++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 0, -1, -1, rise);
      model_push(d);
    end
    check("t5_full", count, DEPTH);
    send_frame(8'h55, 0, PUSH_CYCLE, -1, rise);
    void'(q.pop_front());
    model_push(8'h55);
    check("t5_ovr", ovr, 0);
    check("t5_count", count, DEPTH);
    for (int k = 0; k < 3; k++) pop_check("t5_pop", q.pop_front());
    check("t5_tail", rx_data, 8'h55);
    pop_check("t5_tail_pop", q.pop_front());
    check("t5_empty", count, 0);

    // Test 6: reset in the middle of DATA
    send_frame(8'hC3, 0, -1, -1, rise);
    check("t6_stored", count, 1);
    send_frame(8'h5A, 0, -1, 4 * BIT_CLK, rise);
    reset = 1'b1;
    #1;
    check("t6_rst_data", rx_data, 0);
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_ferr", ferr, 0);
    check("t6_rst_ovr", ovr, 0);
    check("t6_rst_irq", irq, 0);
    UART_RX = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    send_frame(8'h7E, 0, -1, -1, rise);
    check("t6_count", count, 1);
    check("t6_ferr", ferr, 0);
    pop_check("t6_data", 8'h7E);

    // Randomized traffic against the queue model
    for (int n = 0; n < 6; n++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, 0, -1, -1, rise);
      model_push(d);
      check("rnd_count", count, q.size());
      check("rnd_head", rx_data, q[0]);
      check("rnd_ovr", ovr, model_ovr);
      check("rnd_ferr", ferr, 0);
      if ($urandom_range(0, 1) == 1) pop_check("rnd_pop", q.pop_front());
    end
    while (q.size() > 0) pop_check("rnd_drain", q.pop_front());
    check("rnd_empty", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
